exec_stage: RTL

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/exec_stage.sv
// Integer execute stage: ALU, branches, jumps and an optional multiplier (EXEC_STAGE_MUL_EN).
// Latency: single-cycle ops 1 cycle; MUL/MULH/MULHSU/MULHU XLEN+1 cycles.
// Backpressure: the result is held while out_ready=0; in_ready refills HOLD only when out_ready=1.
module exec_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [PC_W-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic [PC_W-1:0] out_target,
    output logic            out_illegal,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);

`ifdef EXEC_STAGE_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} state_t;
`endif

    state_t state;

    logic [SH_W-1:0] shamt;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [PC_W-1:0] jalr_target;
    logic            lt_s, lt_u, eq;

    logic [XLEN-1:0] alu_result;
    logic            alu_taken;
    logic [PC_W-1:0] alu_target;
    logic            alu_illegal;

    assign shamt       = in_b[SH_W-1:0];
    assign pc_plus4    = in_pc + PC_W'(4);
    assign br_target   = in_pc + in_imm[PC_W-1:0];
    assign jalr_sum    = in_a + in_imm;
    assign jalr_target = jalr_sum[PC_W-1:0] & ~PC_W'(1);
    assign lt_s        = $signed(in_a) < $signed(in_b);
    assign lt_u        = in_a < in_b;
    assign eq          = in_a == in_b;

    // Everything outside ops 0-19 lands in default as illegal; with the
    // multiplier built, ops 20-23 are steered away before this result is used.
    always_comb begin
        alu_result  = '0;
        alu_taken   = 1'b0;
        alu_target  = '0;
        alu_illegal = 1'b0;
        case (in_op)
            5'd0:  alu_result = in_a + in_b;
            5'd1:  alu_result = in_a - in_b;
            5'd2:  alu_result = in_a << shamt;
            5'd3:  alu_result = XLEN'(lt_s);
            5'd4:  alu_result = XLEN'(lt_u);
            5'd5:  alu_result = in_a ^ in_b;
            5'd6:  alu_result = in_a >> shamt;
            5'd7:  alu_result = $signed(in_a) >>> shamt;
            5'd8:  alu_result = in_a | in_b;
            5'd9:  alu_result = in_a & in_b;
            5'd10: begin alu_taken = eq;    alu_target = br_target; end
            5'd11: begin alu_taken = !eq;   alu_target = br_target; end
            5'd12: begin alu_taken = lt_s;  alu_target = br_target; end
            5'd13: begin alu_taken = !lt_s; alu_target = br_target; end
            5'd14: begin alu_taken = lt_u;  alu_target = br_target; end
            5'd15: begin alu_taken = !lt_u; alu_target = br_target; end
            5'd16: alu_result = in_b;
            5'd17: alu_result = XLEN'(in_pc) + in_b;
            5'd18: begin
                alu_result = XLEN'(pc_plus4);
                alu_taken  = 1'b1;
                alu_target = br_target;
            end
            5'd19: begin
                alu_result = XLEN'(pc_plus4);
                alu_taken  = 1'b1;
                alu_target = jalr_target;
            end
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef EXEC_STAGE_MUL_EN
    logic                  is_mul;
    logic                  a_neg, b_neg;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic [2*XLEN-1:0]     acc, mcand, acc_next, prod;
    logic [XLEN-1:0]       mplier;
    logic                  mul_neg, mul_hi;
    logic [SH_W-1:0]       cnt;
    logic [XLEN-1:0]       mul_result;

    // Signed forms are multiplied as magnitudes and the sign applied at the end,
    // so XLEN shift-add steps always cover the full 2*XLEN-bit product.
    assign is_mul     = (in_op >= 5'd20) && (in_op <= 5'd23);
    assign a_neg      = ((in_op == 5'd21) || (in_op == 5'd22)) && in_a[XLEN-1];
    assign b_neg      = (in_op == 5'd21) && in_b[XLEN-1];
    assign a_mag      = a_neg ? -in_a : in_a;
    assign b_mag      = b_neg ? -in_b : in_b;
    assign acc_next   = mplier[0] ? acc + mcand : acc;
    assign prod       = mul_neg ? -acc_next : acc_next;
    assign mul_result = mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign busy       = (state == S_MUL);
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !rst && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_taken   <= 1'b0;
            out_target  <= '0;
            out_illegal <= 1'b0;
`ifdef EXEC_STAGE_MUL_EN
            cnt         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    if (in_valid && in_ready) begin
`ifdef EXEC_STAGE_MUL_EN
                        if (is_mul) begin
                            state     <= S_MUL;
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            acc       <= '0;
                            mcand     <= {{XLEN{1'b0}}, a_mag};
                            mplier    <= b_mag;
                            mul_neg   <= a_neg ^ b_neg;
                            mul_hi    <= (in_op != 5'd20);
                        end else
`endif
                        begin
                            state       <= S_HOLD;
                            out_valid   <= 1'b1;
                            out_result  <= alu_result;
                            out_taken   <= alu_taken;
                            out_target  <= alu_target;
                            out_illegal <= alu_illegal;
                        end
                    end else if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef EXEC_STAGE_MUL_EN
                S_MUL: begin
                    cnt    <= cnt + SH_W'(1);
                    acc    <= acc_next;
                    mcand  <= {mcand[2*XLEN-2:0], 1'b0};
                    mplier <= mplier >> 1;
                    if (cnt == SH_W'(XLEN - 1)) begin
                        state       <= S_HOLD;
                        out_valid   <= 1'b1;
                        out_result  <= mul_result;
                        out_taken   <= 1'b0;
                        out_target  <= '0;
                        out_illegal <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
